// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: a WIDTH-bit operand pair is processed LSB-first,
// DIGIT bits per clock, through a DIGIT-bit ripple chain with the carry registered
// between digits. Valid/ready handshakes on both sides allow the consumer to stall.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("digit_serial_adder: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
  end

  localparam int unsigned NDIG = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig, b_dig, dsum;
  logic [DIGIT:0]   c;
  int unsigned      base;

  // Ripple chain of full-adder cells over the current digit.
  always_comb begin
    base  = 32'(cnt_q) * DIGIT;
    a_dig = DIGIT'(a_q >> base);
    b_dig = DIGIT'(b_q >> base);
    c     = '0;
    dsum  = '0;
    c[0]  = carry_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dsum[i] = a_dig[i] ^ b_dig[i] ^ c[i];
      c[i+1]  = (a_dig[i] & b_dig[i]) | (a_dig[i] & c[i]) | (b_dig[i] & c[i]);
    end
  end

  // Next-state logic for the handshake FSM and the datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + 1; borrow-in removes that +1.
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        sum_d[base +: DIGIT] = dsum;
        carry_d              = c[DIGIT];
        if (cnt_q == LastCnt) begin
          cout_d  = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs are decoded straight from state.
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder with three instances: DIGIT=4, DIGIT=1, DIGIT=16.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv = '0;
  logic [2:0]  ordy = '0;
  logic [2:0]  ir, ov, co, of;
  logic [15:0] sw [3];
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int lat_of [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sw[0]), .cout(co[0]), .ovf(of[0])
  );
  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sw[1]), .cout(co[1]), .ovf(of[1])
  );
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sw[2]), .cout(co[2]), .ovf(of[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] ye;
    logic [16:0] r;
    logic        v;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + 17'(ci ^ s);
    v  = (x[15] == ye[15]) && (r[15] != x[15]);
    return {v, r[16], r[15:0]};
  endfunction

  task automatic run_op(input int w, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts, input logic [15:0] es,
                        input logic ec, input logic eo);
    int lat;
    check("in_ready_idle", 32'(ir[w]), 1);
    a = ta; b = tb; cin = tc; sub = ts; iv[w] = 1'b1;
    step();
    iv[w] = 1'b0;
    // Scramble operands; the in-flight op must ignore them.
    a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
    check("in_ready_busy", 32'(ir[w]), 0);
    lat = 0;
    while (!ov[w] && lat < 100) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_of[w]));
    check("sum", 32'(sw[w]), 32'(es));
    check("cout", 32'(co[w]), 32'(ec));
    check("ovf", 32'(of[w]), 32'(eo));
    ordy[w] = 1'b1;
    step();
    ordy[w] = 1'b0;
    check("out_valid_drop", 32'(ov[w]), 0);
    check("in_ready_back", 32'(ir[w]), 1);
  endtask

  initial begin
    int cnt;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] m;

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(ir[0]), 0);
    check("rst_out_valid", 32'(ov[0]), 0);
    check("rst_sum", 32'(sw[0]), 0);
    check("rst_cout", 32'(co[0]), 0);
    check("rst_ovf", 32'(of[0]), 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(ir[0]), 1);

    // Directed vectors on DIGIT=4
    run_op(0, 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op(0, 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
    run_op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Backpressure: hold DONE for 10 cycles while inputs wiggle
    a = 16'h1234; b = 16'h0FED; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    cnt = 0;
    while (!ov[0] && cnt < 100) begin
      step();
      cnt++;
    end
    check("bp_latency", 32'(cnt), 4);
    for (int i = 0; i < 10; i++) begin
      iv[0] = ~iv[0]; a = 16'($urandom); b = 16'($urandom); sub = ~sub; cin = ~cin;
      step();
      check("bp_sum", 32'(sw[0]), 32'h2221);
      check("bp_cout", 32'(co[0]), 0);
      check("bp_ovf", 32'(of[0]), 0);
      check("bp_in_ready", 32'(ir[0]), 0);
      check("bp_out_valid", 32'(ov[0]), 1);
    end
    // in_valid high on the output handshake edge must not be accepted
    iv[0] = 1'b1; ordy[0] = 1'b1;
    step();
    iv[0] = 1'b0; ordy[0] = 1'b0;
    check("bp_release_ready", 32'(ir[0]), 1);
    check("bp_release_valid", 32'(ov[0]), 0);
    step();
    check("bp_no_accept", 32'(ir[0]), 1);

    // Parameter sweep: DIGIT=1 and DIGIT=16 against the model
    for (int w = 1; w < 3; w++) begin
      for (int i = 0; i < 6; i++) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        m = model(ra, rb, rc, rs);
        run_op(w, ra, rb, rc, rs, m[15:0], m[16], m[17]);
      end
    end
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(2, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Reset mid-BUSY after two digits
    a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(ov[0]), 0);
    check("mid_rst_sum", 32'(sw[0]), 0);
    check("mid_rst_cout", 32'(co[0]), 0);
    check("mid_rst_in_ready", 32'(ir[0]), 0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(ir[0]), 1);
    cnt = 0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov[0]) cnt++;
    end
    ordy[0] = 1'b0;
    check("post_rst_no_result", 32'(cnt), 0);
    check("post_rst_sum", 32'(sw[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
